multicycle_control_fsm: RTL and testbench



---
 rtl/multicycle_control_fsm_if.sv | 42 ++++
 rtl/multicycle_control_fsm.sv | 146 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The controller (master) consumes opcode/funct/flags and drives the enables.
// Handshake: i_MemReady high in a cycle means the memory finishes the
// pending access on that rising edge; the controller stays in its
// memory state while it is low. There is no timeout.
`timescale 1ns/1ps
interface multicycle_control_fsm_if;
  logic [5:0] i_Op;
  logic [5:0] i_Funct;
  logic       i_Zero;
  logic       i_MemReady;
  logic       o_IorD;
  logic       o_MemWrite;
  logic       o_IRWrite;
  logic       o_PCWrite;
  logic       o_Branch;
  logic       o_PCEn;
  logic [1:0] o_PCSrc;
  logic       o_ALUSrcA;
  logic [1:0] o_ALUSrcB;
  logic [2:0] o_ALUControl;
  logic       o_RegDst;
  logic       o_MemtoReg;
  logic       o_RegWrite;
  logic       o_InstrDone;
  logic       o_Illegal;
  logic [3:0] o_State;

  modport master (
    input  i_Op, i_Funct, i_Zero, i_MemReady,
    output o_IorD, o_MemWrite, o_IRWrite, o_PCWrite, o_Branch, o_PCEn,
           o_PCSrc, o_ALUSrcA, o_ALUSrcB, o_ALUControl, o_RegDst,
           o_MemtoReg, o_RegWrite, o_InstrDone, o_Illegal, o_State
  );

  modport slave (
    output i_Op, i_Funct, i_Zero, i_MemReady,
    input  o_IorD, o_MemWrite, o_IRWrite, o_PCWrite, o_Branch, o_PCEn,
           o_PCSrc, o_ALUSrcA, o_ALUSrcB, o_ALUControl, o_RegDst,
           o_MemtoReg, o_RegWrite, o_InstrDone, o_Illegal, o_State
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main controller: fetch, decode and per-instruction execute
// states, one per clock. Static per-state controls are registered from the
// next state; strobes that depend on i_MemReady, i_Zero or the opcode in
// DECODE are combined from registered qualifiers, and write strobes are
// masked while reset is asserted.
`timescale 1ns/1ps
module multicycle_control_fsm (
  input logic                    i_Clk,
  input logic                    i_Reset,
  multicycle_control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR  = 4'd2,
    S_MEMREAD  = 4'd3,  S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,  S_ALUWB    = 4'd7,  S_BRANCH  = 4'd8,
    S_ADDIEXEC = 4'd9,  S_ADDIWB   = 4'd10, S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Registered per-state controls. fetch/decode/mw_wait mark the states
  // whose strobes are qualified combinationally.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       pcwrite;
    logic       fetch;
    logic       decode;
    logic       mw_wait;
    logic       branch;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       done;
  } ctl_t;

  state_t r_state;
  ctl_t   r_ctl;
  state_t w_next;
  logic   w_run;
  logic   w_illegal;
  logic   w_pcwrite;

  function automatic logic [2:0] f_alu_funct(input logic [5:0] funct);
    case (funct)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic state_t f_next(input state_t s, input logic [5:0] op,
                                    input logic rdy);
    case (s)
      S_FETCH:    return rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: return S_MEMADR;
          OP_RTYPE:     return S_EXECUTE;
          OP_BEQ:       return S_BRANCH;
          OP_ADDI:      return S_ADDIEXEC;
          OP_J:         return S_JUMP;
          default:      return S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR; anything but sw is treated as a load.
      S_MEMADR:   return (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  return rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: return rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  return S_ALUWB;
      S_ADDIEXEC: return S_ADDIWB;
      default:    return S_FETCH;
    endcase
  endfunction

  function automatic ctl_t f_ctl(input state_t s, input logic [5:0] funct);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.fetch = 1'b1; c.srcb = 2'b01; c.alu = 3'b010; end
      S_DECODE:   begin c.decode = 1'b1; c.srcb = 2'b11; c.alu = 3'b010; end
      S_MEMADR:   begin c.srca = 1'b1; c.srcb = 2'b10; c.alu = 3'b010; end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
      S_MEMWRITE: begin c.iord = 1'b1; c.memwrite = 1'b1; c.mw_wait = 1'b1; end
      S_EXECUTE:  begin c.srca = 1'b1; c.alu = f_alu_funct(funct); end
      S_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
      S_BRANCH: begin
        c.srca = 1'b1; c.alu = 3'b110; c.pcsrc = 2'b01;
        c.branch = 1'b1; c.done = 1'b1;
      end
      S_ADDIEXEC: begin c.srca = 1'b1; c.srcb = 2'b10; c.alu = 3'b010; end
      S_ADDIWB:   begin c.regwrite = 1'b1; c.done = 1'b1; end
      S_JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign w_next = f_next(r_state, bus.i_Op, bus.i_MemReady);

  // State register plus controls registered from the state being entered.
  // Funct is sampled on the DECODE->EXECUTE edge, when the IR is stable.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= S_FETCH;
      r_ctl   <= f_ctl(S_FETCH, 6'd0);
    end else begin
      r_state <= w_next;
      r_ctl   <= f_ctl(w_next, bus.i_Funct);
    end
  end

  assign w_run     = ~i_Reset;
  assign w_illegal = r_ctl.decode &
                     !(bus.i_Op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
  assign w_pcwrite = w_run & (r_ctl.pcwrite | (r_ctl.fetch & bus.i_MemReady));

  assign bus.o_IorD       = r_ctl.iord;
  assign bus.o_MemWrite   = w_run & r_ctl.memwrite;
  assign bus.o_IRWrite    = w_run & r_ctl.fetch & bus.i_MemReady;
  assign bus.o_PCWrite    = w_pcwrite;
  assign bus.o_Branch     = r_ctl.branch;
  assign bus.o_PCEn       = w_run & (w_pcwrite | (r_ctl.branch & bus.i_Zero));
  assign bus.o_PCSrc      = r_ctl.pcsrc;
  assign bus.o_ALUSrcA    = r_ctl.srca;
  assign bus.o_ALUSrcB    = r_ctl.srcb;
  assign bus.o_ALUControl = r_ctl.alu;
  assign bus.o_RegDst     = r_ctl.regdst;
  assign bus.o_MemtoReg   = r_ctl.memtoreg;
  assign bus.o_RegWrite   = w_run & r_ctl.regwrite;
  assign bus.o_InstrDone  = w_run & (r_ctl.done | (r_ctl.mw_wait & bus.i_MemReady) | w_illegal);
  assign bus.o_Illegal    = w_run & w_illegal;
  assign bus.o_State      = r_state;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for the multicycle controller. Each instruction is expanded into its
// expected per-cycle control trace (fetch with waits, decode, then the
// instruction's own phases) and replayed against the DUT cycle by cycle.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;
  typedef struct packed {
    logic [3:0] st;
    logic       iord, memwrite, irwrite, pcwrite, branch, pcen;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       regdst, memtoreg, regwrite, done, illegal;
  } ctl_t;
  localparam int W = $bits(ctl_t);

  // clock / reset
  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  always #5 i_Clk = ~i_Clk;

  multicycle_control_fsm_if bus ();
  multicycle_control_fsm dut (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(bus));

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           zero_mode = 0;   // 0 random, 1 force 1, 2 force 0

  function automatic ctl_t st_only(input int s);
    ctl_t c;
    c = '0;
    c.st = 4'(s);
    return c;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic supported(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.st = bus.o_State;       o.iord = bus.o_IorD;
    o.memwrite = bus.o_MemWrite; o.irwrite = bus.o_IRWrite;
    o.pcwrite = bus.o_PCWrite; o.branch = bus.o_Branch;
    o.pcen = bus.o_PCEn;      o.pcsrc = bus.o_PCSrc;
    o.srca = bus.o_ALUSrcA;   o.srcb = bus.o_ALUSrcB;
    o.alu = bus.o_ALUControl; o.regdst = bus.o_RegDst;
    o.memtoreg = bus.o_MemtoReg; o.regwrite = bus.o_RegWrite;
    o.done = bus.o_InstrDone; o.illegal = bus.o_Illegal;
    return o;
  endfunction

  function automatic ctl_t fetch_exp(input logic rdy);
    ctl_t c;
    c = st_only(0);
    c.srcb = 2'b01; c.alu = 3'b010;
    c.irwrite = rdy; c.pcwrite = rdy;
    return c;
  endfunction

  // driver: one clock cycle, inputs at negedge, outputs checked 1ns later
  task automatic run_cycle(input logic rst, input logic rdy, input ctl_t e,
                           input string tag);
    ctl_t o;
    logic z;
    @(negedge i_Clk);
    cyc++;
    case (zero_mode)
      1:       z = 1'b1;
      2:       z = 1'b0;
      default: z = 1'($urandom_range(0, 1));
    endcase
    i_Reset = rst;
    bus.i_MemReady = rdy;
    bus.i_Zero = z;
    e.pcen = e.pcwrite | (e.branch & z);
    if (rst) begin
      e.memwrite = 1'b0; e.irwrite = 1'b0; e.pcwrite = 1'b0; e.pcen = 1'b0;
      e.regwrite = 1'b0; e.done = 1'b0; e.illegal = 1'b0;
    end
    #1;
    o = observe();
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
  endtask

  task automatic push(input ctl_t c, input logic rdy);
    exp_q.push_back(c);
    rdy_q.push_back(rdy);
  endtask

  // reference model: expected trace for one instruction
  task automatic build_instr(input logic [5:0] op, input logic [5:0] f,
                             input int fw, input int mw);
    ctl_t c;
    for (int k = 0; k <= fw; k++) push(fetch_exp(k == fw), k == fw);
    c = st_only(1); c.srcb = 2'b11; c.alu = 3'b010;
    if (!supported(op)) begin
      c.illegal = 1'b1; c.done = 1'b1;
      push(c, 1'($urandom_range(0, 1)));
      return;
    end
    push(c, 1'($urandom_range(0, 1)));
    case (op)
      6'b100011, 6'b101011: begin
        c = st_only(2); c.srca = 1'b1; c.srcb = 2'b10; c.alu = 3'b010;
        push(c, 1'($urandom_range(0, 1)));
        for (int k = 0; k <= mw; k++) begin
          if (op == 6'b100011) begin
            c = st_only(3); c.iord = 1'b1;
          end else begin
            c = st_only(5); c.iord = 1'b1; c.memwrite = 1'b1; c.done = (k == mw);
          end
          push(c, k == mw);
        end
        if (op == 6'b100011) begin
          c = st_only(4); c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1;
          push(c, 1'($urandom_range(0, 1)));
        end
      end
      6'b000000: begin
        c = st_only(6); c.srca = 1'b1; c.alu = funct_alu(f);
        push(c, 1'($urandom_range(0, 1)));
        c = st_only(7); c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1;
        push(c, 1'($urandom_range(0, 1)));
      end
      6'b000100: begin
        c = st_only(8); c.srca = 1'b1; c.alu = 3'b110; c.pcsrc = 2'b01;
        c.branch = 1'b1; c.done = 1'b1;
        push(c, 1'($urandom_range(0, 1)));
      end
      6'b001000: begin
        c = st_only(9); c.srca = 1'b1; c.srcb = 2'b10; c.alu = 3'b010;
        push(c, 1'($urandom_range(0, 1)));
        c = st_only(10); c.regwrite = 1'b1; c.done = 1'b1;
        push(c, 1'($urandom_range(0, 1)));
      end
      default: begin
        c = st_only(11); c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1;
        push(c, 1'($urandom_range(0, 1)));
      end
    endcase
  endtask

  // load the IR fields once the DUT is in FETCH, then replay the trace
  task automatic do_instr(input logic [5:0] op, input logic [5:0] f,
                          input int fw, input int mw, input string tag);
    ctl_t e;
    logic r;
    build_instr(op, f, fw, mw);
    @(posedge i_Clk);
    #1;
    bus.i_Op = op;
    bus.i_Funct = f;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      run_cycle(1'b0, r, e, tag);
    end
  endtask

  initial begin
    ctl_t e;
    logic r;
    logic [5:0] op;
    logic [5:0] f;
    bus.i_Op = 6'd0; bus.i_Funct = 6'd0; bus.i_Zero = 1'b0; bus.i_MemReady = 1'b0;

    // reset: strobes masked even with memory ready in FETCH
    repeat (2) @(posedge i_Clk);
    run_cycle(1'b1, 1'b1, fetch_exp(1'b1), "reset");
    run_cycle(1'b0, 1'b0, fetch_exp(1'b0), "idle_fetch");

    do_instr(6'b000000, 6'b100000, 0, 0, "add");
    do_instr(6'b100011, 6'd0, 2, 3, "lw_waits");
    zero_mode = 1;
    do_instr(6'b000100, 6'd0, 0, 0, "beq_z1");
    zero_mode = 2;
    do_instr(6'b000100, 6'd0, 0, 0, "beq_z0");
    zero_mode = 0;
    do_instr(6'b101011, 6'd0, 0, 2, "sw");
    do_instr(6'b000010, 6'd0, 0, 0, "j");
    do_instr(6'b111111, 6'd0, 0, 0, "illegal");
    do_instr(6'b000000, 6'b100010, 0, 0, "funct_sub");
    do_instr(6'b000000, 6'b100100, 0, 0, "funct_and");
    do_instr(6'b000000, 6'b100101, 0, 0, "funct_or");
    do_instr(6'b000000, 6'b101010, 0, 0, "funct_slt");
    do_instr(6'b000000, 6'b000000, 0, 0, "funct_dflt");
    do_instr(6'b001000, 6'd0, 1, 0, "addi");

    // reset for two cycles in the middle of a MEMWRITE wait
    build_instr(6'b101011, 6'd0, 0, 5);
    @(posedge i_Clk);
    #1;
    bus.i_Op = 6'b101011;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      run_cycle(1'b0, r, e, "sw_pre_rst");
    end
    e = exp_q.pop_front();
    run_cycle(1'b1, 1'b0, e, "rst_mid_sw");
    run_cycle(1'b1, 1'b1, fetch_exp(1'b1), "rst_second");
    exp_q.delete();
    rdy_q.delete();
    run_cycle(1'b0, 1'b0, fetch_exp(1'b0), "post_rst");

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: begin
          op = 6'($urandom);
          while (supported(op)) op = 6'($urandom);
        end
      endcase
      case ($urandom_range(0, 5))
        0: f = 6'b100000;
        1: f = 6'b100010;
        2: f = 6'b100100;
        3: f = 6'b100101;
        4: f = 6'b101010;
        default: f = 6'($urandom);
      endcase
      do_instr(op, f, $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
